// File: rtl/ds_sample_interpolator.sv
// ds_sample_interpolator: FIFO-buffered 2^L upsampler feeding the delta-sigma modulator's u.
// Define DS_INTERP_LINEAR_EN for linear interpolation; otherwise each sample is held (zero-order hold).
module ds_sample_interpolator #(
   parameter int IN_BITS    = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int L_BITS     = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IN_BITS-1:0] in_sample,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [L_BITS-1:0]  interp_log2,
   input  logic               take,
   output logic [IN_BITS-1:0] u,
   output logic               underrun,
   input  logic               underrun_clear
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int K_W = 2**L_BITS - 1;
   localparam int ACC_W = IN_BITS + K_W;
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] HALF = (AW+1)'(FIFO_DEPTH/2);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;

   logic [IN_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] count;
   logic push, pop, seg_end, set_ur;
   logic [IN_BITS-1:0] head, x1, x1_n, u_n;
   logic [K_W-1:0] k, k_n;
   logic [L_BITS-1:0] l_cur, l_n;
`ifdef DS_INTERP_LINEAR_EN
   logic signed [IN_BITS:0] delta, delta_n;
   logic [ACC_W-1:0] acc, acc_n;
`endif

   assign in_ready = count != FULL;
   assign push = in_valid & in_ready;
   assign head = mem[rd_ptr];
   assign seg_end = k == K_W'((1 << l_cur) - 1);

   always_comb begin
      state_n = state;
      pop = 1'b0;
      set_ur = 1'b0;
      x1_n = x1;
      k_n = k;
      l_n = l_cur;
`ifdef DS_INTERP_LINEAR_EN
      delta_n = delta;
      acc_n = acc;
`endif
      if (state == IDLE) begin
         if (count >= HALF) begin
            state_n = RUN;
            pop = 1'b1;
            x1_n = head;
            k_n = '0;
            l_n = interp_log2;
`ifdef DS_INTERP_LINEAR_EN
            delta_n = '0;
            acc_n = ACC_W'(head) << interp_log2;
`endif
         end
      end else if (take) begin
         if (!seg_end) begin
            k_n = k + 1'b1;
`ifdef DS_INTERP_LINEAR_EN
            acc_n = acc + ACC_W'(delta);
`endif
         end else begin
            pop = count != '0;
            set_ur = !pop;
            x1_n = pop ? head : x1;
            k_n = '0;
            l_n = interp_log2;
`ifdef DS_INTERP_LINEAR_EN
            // Restart from the previous target; the new slope walks acc toward the popped sample.
            delta_n = pop ? $signed({1'b0, head}) - $signed({1'b0, x1}) : '0;
            acc_n = ACC_W'(x1) << interp_log2;
`endif
         end
      end
`ifdef DS_INTERP_LINEAR_EN
      u_n = IN_BITS'(acc_n >> l_n);
`else
      u_n = x1_n;
`endif
   end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= in_sample;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         x1 <= '0;
         k <= '0;
         l_cur <= '0;
         u <= '0;
         underrun <= 1'b0;
`ifdef DS_INTERP_LINEAR_EN
         delta <= '0;
         acc <= '0;
`endif
      end else begin
         state <= state_n;
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         x1 <= x1_n;
         k <= k_n;
         l_cur <= l_n;
         u <= u_n;
         underrun <= set_ur | (underrun & ~underrun_clear);
`ifdef DS_INTERP_LINEAR_EN
         delta <= delta_n;
         acc <= acc_n;
`endif
      end
   end
endmodule

// File: tb/tb_ds_sample_interpolator.sv
// tb_ds_sample_interpolator: scoreboard bench; expected u per take is queued, a monitor checks each consumed value.
module tb_ds_sample_interpolator;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [15:0] in_sample = '0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [2:0] interp_log2 = '0;
   logic take = 1'b0;
   logic [15:0] u;
   logic underrun;
   logic underrun_clear = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   ds_sample_interpolator #(.IN_BITS(16), .FIFO_DEPTH(4), .L_BITS(3)) dut (
      .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
      .interp_log2(interp_log2), .take(take), .u(u), .underrun(underrun), .underrun_clear(underrun_clear)
   );

   task automatic check(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (take) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u_unexpected_take: got %0h with no expected value queued", u);
         end else
            check("u", u, exp_q.pop_front());
      end

   // Values consumed over one segment x0 -> x1 at ratio 2^l.
   task automatic seg(int x0, int x1, int l);
      for (int k = 0; k < (1 << l); k++)
`ifdef DS_INTERP_LINEAR_EN
         exp_q.push_back(16'((x0 * (1 << l) + k * (x1 - x0)) >>> l));
`else
         exp_q.push_back(16'(x1));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      take = 1'b0;
      underrun_clear = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push(int v);
      in_sample = 16'(v);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic takes(int n);
      for (int i = 0; i < n; i++) begin
         take = 1'b1;
         tick();
      end
      take = 1'b0;
   endtask

   task automatic start_run(int l, int a, int b);
      do_reset();
      interp_log2 = 3'(l);
      push(a);
      push(b);
      tick();
      tick();
   endtask

   initial begin
      int accepted;
      do_reset();
      check("reset_u", u, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_underrun", underrun, 0);
      repeat (3) exp_q.push_back(16'h0);
      takes(3);
      check("idle_underrun", underrun, 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_u", u, 0);

      start_run(2, 'h1000, 'h2000);
      seg('h1000, 'h1000, 2);
      seg('h1000, 'h2000, 2);
      seg('h2000, 'h2000, 2);
      takes(7);
      check("underrun_before_end", underrun, 0);
      takes(1);
      check("underrun_at_end", underrun, 1);
      takes(4);
      check("u_hold", u, 'h2000);
      underrun_clear = 1'b1;
      tick();
      underrun_clear = 1'b0;
      check("underrun_cleared", underrun, 0);

      start_run(1, 'h0000, 'h0003);
      seg(0, 0, 1);
      seg(0, 3, 1);
      takes(4);

      start_run(2, 'h2000, 'h1000);
      seg('h2000, 'h2000, 2);
      seg('h2000, 'h1000, 2);
      takes(8);

      start_run(2, 'h0100, 'h0200);
      seg('h100, 'h100, 2);
      takes(4);
      accepted = 0;
      for (int i = 0; i < 8; i++) begin
         in_sample = 16'('h300 + accepted * 'h100);
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) accepted++;
         tick();
      end
      in_valid = 1'b0;
      check("bp_accepted", accepted, 4);
      check("bp_in_ready_low", in_ready, 0);
      seg('h100, 'h200, 2);
      takes(3);
      take = 1'b1;
      @(negedge clk);
      check("bp_in_ready_at_pop", in_ready, 0);
      tick();
      take = 1'b0;
      check("bp_in_ready_rise", in_ready, 1);

      start_run(2, 'h1000, 'h2000);
      push('h3000);
      push('h4000);
      seg('h1000, 'h1000, 2);
      seg('h1000, 'h2000, 0);
      seg('h2000, 'h3000, 0);
      seg('h3000, 'h4000, 0);
      seg('h4000, 'h4000, 0);
      takes(1);
      interp_log2 = 3'd0;
      takes(7);
      check("lchg_underrun", underrun, 1);
      push('h5000);
      push('h6000);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset_u", u, 0);
      check("midreset_underrun", underrun, 0);
      check("midreset_in_ready", in_ready, 1);
      push('h7000);
      tick();
      tick();
      repeat (2) exp_q.push_back(16'h0);
      takes(2);
      check("midreset_fifo_flushed", u, 0);

      tick();
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ds_sample_interpolator.md
# ds_sample_interpolator

Upstream feeder for `delta_sigma_modulator` / `delta_sigma_pw_modulator`. It accepts audio-rate samples over a valid/ready handshake into a small FIFO and presents an upsampled input `u` to the modulator. Each modulator sample slot consumes one interpolated value, produced by linear interpolation between successive samples at a programmable 2^L ratio. The FIFO absorbs jitter between the host sample clock and the PWM period.

## Interface
- `IN_BITS`, 16: sample and `u` width (unsigned, same encoding as the modulator's `u`).
- `FIFO_DEPTH`, 4: FIFO entries. Power of 2, at least 2.
- `L_BITS`, 3: width of `interp_log2`. Maximum ratio is 2^(2^L_BITS−1).

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_sample` in IN_BITS: incoming sample.
- `in_valid` in 1: sample offered.
- `in_ready` out 1: FIFO not full. A transfer happens when `in_valid & in_ready`.
- `interp_log2` in L_BITS: log2 of the interpolation ratio. It is latched at segment start.
- `take` in 1: single-cycle consume strobe from the modulator side, `y_valid_out & pulse_done`.
- `u` out IN_BITS: registered value to the modulator's `u`.
- `underrun` out 1: sticky flag, set when a segment ends with the FIFO empty.
- `underrun_clear` in 1: clears `underrun`.

## Operation
- FIFO: circular buffer with a count register.
  - Push on `in_valid & in_ready`; pop is internal.
  - Push and pop in the same cycle leaves the count unchanged.
  - No bypass: a sample pushed into an empty FIFO becomes poppable the next cycle.
- Datapath registers:
  - `x1`: segment target.
  - `delta`: IN_BITS+1 signed.
  - `acc`: IN_BITS+2^L_BITS−1 bits, unsigned.
  - `k`: phase counter.
  - `L_cur`: latched ratio.
  - `u = acc >> L_cur` (floor).
- States:
  - IDLE: `u=0`. `take` is ignored and `underrun` is never set. Go to RUN when count ≥ FIFO_DEPTH/2, popping s: `x1=s`, `delta=0`, `acc=s<<L`, `k=0`, `L_cur=interp_log2`.
  - RUN, on `take` with `k < 2^L_cur−1`: `k++`, `acc += delta`.
  - RUN, on `take` with `k = 2^L_cur−1` (segment end), FIFO non-empty: pop s, `delta = s − x1`, `acc = x1<<L`, `x1 = s`, `k = 0`, `L_cur = interp_log2`.
  - RUN, segment end with FIFO empty: `delta = 0`, `acc = x1<<L`, `k = 0`, `L_cur = interp_log2`, `underrun = 1`. The last sample is held; there is no return to IDLE.
  - In both segment-end cases, L is the newly latched `interp_log2`.
- Segment values: segment x0→x1 yields `x0 + floor(k·(x1−x0)/2^L)` for k = 0..2^L−1. `acc` never goes negative or overflows.
- `interp_log2` changes mid-segment take effect only at the next segment start.
- Same-cycle `underrun_clear` and set: the set wins.

## Timing
- Reset values: `u=0`, `in_ready=1`, `underrun=0`, state IDLE, FIFO empty, `k=0`, `acc=0`, `x1=0`, `delta=0`.
- `u` updates on the clock edge after the cycle in which `take` is sampled high. It is stable from there until the next `take`, which satisfies the modulator holding `u` through state 0.
- Push latency: a sample is available for pop one cycle after its handshake.
- `in_ready` rises the cycle after a pop frees a full FIFO.
- `take` on consecutive cycles is legal; each pulse advances one step.
- Reset asserted mid-operation restores all reset values on that edge. FIFO contents are discarded.

## Configuration
- `DS_INTERP_LINEAR_EN`:
  - Defined: linear interpolation as above.
  - Undefined: zero-order hold. `delta` is forced to 0, and the subtractor and `acc` adder are removed. Each sample repeats 2^L_cur times and `u = x1`.
  - FIFO, state machine, `k`, `L_cur` and `underrun` behave identically in both builds.

## Test plan
- Reset, then 3 `take` pulses with the FIFO empty → `u=0`, `underrun=0`, `in_ready=1`, state stays IDLE.
- L=2, push 0x1000 and 0x2000 (DEPTH 4), then 12 `take` pulses:
  - `u` = 0x1000 ×4, then 0x1000, 0x1400, 0x1800, 0x1C00, then 0x2000 ×4.
  - `underrun` rises at the second segment end.
- Floor and descending: L=1, pushes 0x0000, 0x0003 → RUN `u`: 0, 0, 0, 1. With pushes 0x2000, 0x1000 at L=2 → descending segment 0x2000, 0x1C00, 0x1800, 0x1400.
- Backpressure in RUN with `take` low: exactly FIFO_DEPTH samples accepted, then `in_ready=0`; a segment-end pop raises `in_ready` one cycle later.
- Change L from 2 to 0 at k=1 → the current segment still takes 4 pulses; subsequent segments take 1 pulse each (`u` equals the raw samples).
- Undefined `DS_INTERP_LINEAR_EN`, L=2, samples 0x1000, 0x2000 → `u` = 0x1000 ×4, then 0x2000 ×4.
